fifo_width_converter_param: RTL and testbench
=============================================

FIFO_WIDTH_CONVERTER_PARAM -- requirements
Module: fifo_width_converter_param

Interface
REQ-001 SHALL have parameter READ_WIDTH, default 4: width of one read word in bits.
REQ-002 SHALL have parameter RATIO, default 2: read words packed into one write word; power of two, 2..2**ADDR_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4: storage depth DEPTH = 2**ADDR_WIDTH read words.
REQ-004 SHALL have parameter ORDER, type order_e, default ORDER_MSB_FIRST: which write-word slice is read first.
REQ-005 SHALL have port clk_i  input  1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_i  input  1: reset, synchronous and active-high.
REQ-007 SHALL have port write_i  input  1: write request.
REQ-008 SHALL have port write_data_i  input  READ_WIDTH*RATIO: write word.
REQ-009 SHALL have port read_i  input  1: read request; pops one read word.
REQ-010 SHALL have port read_data_o  output  READ_WIDTH: word at the read pointer, combinational from storage.
REQ-011 SHALL have port empty_o  output  1: high when count is 0.
REQ-012 SHALL have port full_o  output  1: high when free slots are fewer than RATIO.
REQ-013 SHALL have port count_o  output  ADDR_WIDTH+1: read words currently stored, 0..DEPTH.

Function
REQ-014 SHALL accept a write (wr_acc) only when write_i=1 and full_o=0; otherwise storage, pointer and count are unchanged by the write.
REQ-015 SHALL accept a read (rd_acc) only when read_i=1 and empty_o=0; otherwise the read pointer and count are unchanged by the read.
REQ-016 On wr_acc, SHALL store RATIO slices at write pointer wp..wp+RATIO-1 in the same cycle. ORDER_MSB_FIRST: slot wp+k gets slice k counted from the MSB end. ORDER_LSB_FIRST: slot wp+k gets slice k counted from bit 0.
REQ-017 On wr_acc, SHALL advance wp by RATIO modulo DEPTH; wp is always a multiple of RATIO.
REQ-018 On rd_acc, SHALL advance the read pointer rp by 1 modulo DEPTH; read_data_o then shows mem[rp] after the clock edge.
REQ-019 SHALL update count by +RATIO (wr_acc only), -1 (rd_acc only), or +RATIO-1 (both accepted in the same cycle).
REQ-020 SHALL derive full_o and empty_o combinationally from the registered count: full_o = (count > DEPTH-RATIO); empty_o = (count == 0).
REQ-021 When full with simultaneous write_i and read_i, SHALL perform the read only; the write is dropped, because full_o is evaluated on the current-cycle count.
REQ-022 When empty with simultaneous write_i and read_i, SHALL perform the write only; read_data_o shows the first stored slice in the next cycle.
REQ-023 SHALL wrap both pointers from DEPTH-1 to 0 with no loss or duplication of data.
REQ-024 When empty, read_data_o SHALL be don't-care, and benches SHALL NOT check it.

Reset
REQ-025 On reset_i=1 at a clock edge, SHALL set wp=0, rp=0, count=0; the outputs then read empty_o=1, full_o=0, count_o=0.
REQ-026 Reset SHALL take priority over wr_acc and rd_acc in the same cycle, including reset asserted mid-stream.
REQ-027 Storage contents SHALL NOT be reset.

Structure
REQ-028 SHALL import typedef enum order_e {ORDER_MSB_FIRST, ORDER_LSB_FIRST} from shared package fifo_conv_pkg.
REQ-029 SHALL instantiate one sub-module, multi_write_register_file (params ADDR_WIDTH, DATA_WIDTH, RATIO): RATIO write lanes sharing one enable at aligned base address, one asynchronous read port.
REQ-030 Pointer and count logic SHALL reside in the top module; parameter legality checked by elaboration-time assertion.

Verification
REQ-031 Defaults, reset, write 0xA5, read twice -> read_data_o 0xA then 0x5; empty_o=1 after the second read.
REQ-032 Defaults, ORDER_LSB_FIRST, write 0xA5 -> first read 0x5, second read 0xA.
REQ-033 Defaults, 8 writes 0x10..0x17 -> full_o=1, count_o=16; 9th write ignored; 16 reads return 1,0,1,1,...,1,7.
REQ-034 Full; write_i=1 and read_i=1 same cycle -> count_o 15, full_o=1, write data absent from later reads.
REQ-035 Count 1; write and read same cycle -> count_o 2; sustained streaming across 3 pointer wraps, data matches a scoreboard.
REQ-036 READ_WIDTH=8, RATIO=4, ADDR_WIDTH=3; write 0x11223344; reset_i=1 after 2 reads -> empty_o=1, count_o=0; next write and reads return 0x11 first.

Source files
------------

// File: rtl/fifo_width_converter_param_pkg.sv
// Shared definitions for the width-converting FIFO: slice ordering and
// parameter legality helper.
package fifo_conv_pkg;

    // Which slice of a write word is popped first.
    typedef enum logic {
        ORDER_MSB_FIRST = 1'b0,
        ORDER_LSB_FIRST = 1'b1
    } order_e;

    // RATIO must be a power of two between 2 and the storage depth.
    function automatic bit ratio_is_legal(int ratio, int addr_width);
        return (ratio >= 2) && (ratio <= (1 << addr_width)) && ((ratio & (ratio - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_width_converter_param_if.sv
// Handshake and data bundle of the width-converting FIFO. The master side
// issues writes/reads; the slave side (the FIFO) returns data and status.
interface fifo_width_converter_param_if #(
    parameter int READ_WIDTH = 4,
    parameter int RATIO      = 2,
    parameter int ADDR_WIDTH = 4
);
    logic                          write_i;
    logic [READ_WIDTH*RATIO-1:0]   write_data_i;
    logic                          read_i;
    logic [READ_WIDTH-1:0]         read_data_o;
    logic                          empty_o;
    logic                          full_o;
    logic [ADDR_WIDTH:0]           count_o;

    modport master (
        output write_i, write_data_i, read_i,
        input  read_data_o, empty_o, full_o, count_o
    );

    modport slave (
        input  write_i, write_data_i, read_i,
        output read_data_o, empty_o, full_o, count_o
    );
endinterface

// File: rtl/fifo_width_converter_param_regfile.sv
// Register file with RATIO write lanes sharing one enable and one aligned
// base address, plus a single asynchronous read port.
module multi_write_register_file #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4,
    parameter int RATIO      = 2
) (
    input  logic                                clk_i,
    input  logic                                we_i,
    input  logic [ADDR_WIDTH-1:0]               waddr_i,
    input  logic [RATIO-1:0][DATA_WIDTH-1:0]    wdata_i,
    input  logic [ADDR_WIDTH-1:0]               raddr_i,
    output logic [DATA_WIDTH-1:0]               rdata_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write all lanes at once; lane k lands at base + k.
    // NOTE: storage has no reset -- the pointers define what is valid, and a
    // resettable array would cost a reset net per bit for no functional gain.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < RATIO; k++) begin
                // Base is a multiple of RATIO, so OR-ing the lane index equals adding it.
                mem[waddr_i | ADDR_WIDTH'(k)] <= wdata_i[k];
            end
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_width_converter_param.sv
// FIFO that accepts RATIO read words per write and pops one read word per
// read. Pointers and occupancy count live here; storage is a multi-lane
// register file.
module fifo_width_converter_param
    import fifo_conv_pkg::*;
#(
    parameter int     READ_WIDTH = 4,
    parameter int     RATIO      = 2,
    parameter int     ADDR_WIDTH = 4,
    parameter order_e ORDER      = ORDER_MSB_FIRST
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    fifo_width_converter_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    if (!ratio_is_legal(RATIO, ADDR_WIDTH) || (READ_WIDTH < 1)) begin : g_bad_params
        $fatal(1, "fifo_width_converter_param: RATIO must be a power of two in 2..2**ADDR_WIDTH");
    end

    logic [ADDR_WIDTH-1:0]                wp;
    logic [ADDR_WIDTH-1:0]                rp;
    logic [CNT_W-1:0]                     count;
    logic                                 full;
    logic                                 empty;
    logic                                 wr_acc;
    logic                                 rd_acc;
    logic [RATIO-1:0][READ_WIDTH-1:0]     lanes;

    // Status comes from the registered count only, so a full FIFO drops a
    // same-cycle write even when a read frees a slot.
    assign full   = count > CNT_W'(DEPTH - RATIO);
    assign empty  = (count == '0);
    assign wr_acc = bus.write_i && !full;
    assign rd_acc = bus.read_i && !empty;

    // Lane k receives the k-th slice in pop order.
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        if (ORDER == ORDER_MSB_FIRST) begin : g_msb
            assign lanes[k] = bus.write_data_i[(RATIO-1-k)*READ_WIDTH +: READ_WIDTH];
        end else begin : g_lsb
            assign lanes[k] = bus.write_data_i[k*READ_WIDTH +: READ_WIDTH];
        end
    end

    // Pointer and count update; reset wins over any accepted transfer.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_acc) begin
                wp <= wp + ADDR_WIDTH'(RATIO);
            end
            if (rd_acc) begin
                rp <= rp + ADDR_WIDTH'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(RATIO);
                2'b01:   count <= count - CNT_W'(1);
                2'b11:   count <= count + CNT_W'(RATIO - 1);
                default: count <= count;
            endcase
        end
    end

    multi_write_register_file #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (READ_WIDTH),
        .RATIO      (RATIO)
    ) u_storage (
        .clk_i   (clk_i),
        .we_i    (wr_acc && !reset_i),
        .waddr_i (wp),
        .wdata_i (lanes),
        .raddr_i (rp),
        .rdata_o (bus.read_data_o)
    );

    assign bus.empty_o = empty;
    assign bus.full_o  = full;
    assign bus.count_o = count;

endmodule

// File: tb/tb_fifo_width_converter_param.sv
// Self-checking bench: a queue model tracks the default-configured FIFO on
// every cycle; directed sequences pin the model and cover LSB-first ordering
// and a wide (8-bit x4, depth 8) configuration.
module tb_fifo_width_converter_param;
    import fifo_conv_pkg::*;

    localparam int M_W     = 4;
    localparam int M_RATIO = 2;
    localparam int M_DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic m_rst = 1'b1;
    logic l_rst = 1'b1;
    logic w_rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_width_converter_param_if #(.READ_WIDTH(4), .RATIO(2), .ADDR_WIDTH(4)) m_if ();
    fifo_width_converter_param_if #(.READ_WIDTH(4), .RATIO(2), .ADDR_WIDTH(4)) l_if ();
    fifo_width_converter_param_if #(.READ_WIDTH(8), .RATIO(4), .ADDR_WIDTH(3)) w_if ();

    fifo_width_converter_param #(
        .READ_WIDTH(4), .RATIO(2), .ADDR_WIDTH(4), .ORDER(ORDER_MSB_FIRST)
    ) u_msb (.clk_i(clk), .reset_i(m_rst), .bus(m_if.slave));

    fifo_width_converter_param #(
        .READ_WIDTH(4), .RATIO(2), .ADDR_WIDTH(4), .ORDER(ORDER_LSB_FIRST)
    ) u_lsb (.clk_i(clk), .reset_i(l_rst), .bus(l_if.slave));

    fifo_width_converter_param #(
        .READ_WIDTH(8), .RATIO(4), .ADDR_WIDTH(3), .ORDER(ORDER_MSB_FIRST)
    ) u_wide (.clk_i(clk), .reset_i(w_rst), .bus(w_if.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model for u_msb: a queue of read words in pop order.
    int unsigned q[$];
    bit          model_on = 1'b0;

    always @(posedge clk) begin
        bit wacc;
        bit racc;
        if (m_rst) begin
            q.delete();
            model_on = 1'b1;
        end else begin
            wacc = m_if.write_i && (q.size() + M_RATIO <= M_DEPTH);
            racc = m_if.read_i && (q.size() != 0);
            if (racc) void'(q.pop_front());
            if (wacc) begin
                for (int k = 0; k < M_RATIO; k++)
                    q.push_back((int'(m_if.write_data_i) >> ((M_RATIO - 1 - k) * M_W)) & 'hF);
            end
        end
    end

    // Every-cycle comparison of u_msb against the model, away from the rising edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("cmp_count", 32'(m_if.count_o), q.size());
            check("cmp_empty", 32'(m_if.empty_o), 32'(q.size() == 0));
            check("cmp_full",  32'(m_if.full_o),  32'(q.size() + M_RATIO > M_DEPTH));
            if (q.size() != 0)
                check("cmp_rdata", 32'(m_if.read_data_o), q[0]);
        end
    end

    task automatic mcyc(input logic r, input logic w, input logic [7:0] d, input logic rd);
        @(negedge clk);
        m_rst = r; m_if.write_i = w; m_if.write_data_i = d; m_if.read_i = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic lcyc(input logic r, input logic w, input logic [7:0] d, input logic rd);
        @(negedge clk);
        l_rst = r; l_if.write_i = w; l_if.write_data_i = d; l_if.read_i = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic wcyc(input logic r, input logic w, input logic [31:0] d, input logic rd);
        @(negedge clk);
        w_rst = r; w_if.write_i = w; w_if.write_data_i = d; w_if.read_i = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_if.write_i = 0; m_if.write_data_i = '0; m_if.read_i = 0;
        l_if.write_i = 0; l_if.write_data_i = '0; l_if.read_i = 0;
        w_if.write_i = 0; w_if.write_data_i = '0; w_if.read_i = 0;

        // Reset state.
        mcyc(1, 0, 8'h00, 0);
        check("rst_empty", 32'(m_if.empty_o), 1);
        check("rst_full",  32'(m_if.full_o),  0);
        check("rst_count", 32'(m_if.count_o), 0);

        // One write, two reads, MSB slice first.
        mcyc(0, 1, 8'hA5, 0);
        check("a5_count", 32'(m_if.count_o), 2);
        check("a5_first", 32'(m_if.read_data_o), 32'hA);
        mcyc(0, 0, 8'h00, 1);
        check("a5_second", 32'(m_if.read_data_o), 32'h5);
        mcyc(0, 0, 8'h00, 1);
        check("a5_empty", 32'(m_if.empty_o), 1);

        // Fill to full, overflow write dropped, drain in order.
        for (int i = 0; i < 8; i++) mcyc(0, 1, 8'(8'h10 + i), 0);
        check("fill_full",  32'(m_if.full_o),  1);
        check("fill_count", 32'(m_if.count_o), 16);
        mcyc(0, 1, 8'h99, 0);
        check("ovf_count", 32'(m_if.count_o), 16);
        for (int j = 0; j < 16; j++) begin
            check("drain_data", 32'(m_if.read_data_o), (j % 2 == 0) ? 32'h1 : 32'(j / 2));
            mcyc(0, 0, 8'h00, 1);
        end
        check("drain_empty", 32'(m_if.empty_o), 1);

        // Full with simultaneous write and read: read only.
        for (int i = 0; i < 8; i++) mcyc(0, 1, 8'(8'h20 + i), 0);
        mcyc(0, 1, 8'hEE, 1);
        check("fullrw_count", 32'(m_if.count_o), 15);
        check("fullrw_full",  32'(m_if.full_o),  1);
        for (int j = 1; j < 16; j++) begin
            check("fullrw_data", 32'(m_if.read_data_o), (j % 2 == 0) ? 32'h2 : 32'(j / 2));
            mcyc(0, 0, 8'h00, 1);
        end
        check("fullrw_empty", 32'(m_if.empty_o), 1);

        // Count 1 with simultaneous write and read.
        mcyc(0, 1, 8'h3C, 0);
        mcyc(0, 0, 8'h00, 1);
        check("one_count", 32'(m_if.count_o), 1);
        mcyc(0, 1, 8'h4D, 1);
        check("one_rw_count", 32'(m_if.count_o), 2);
        check("one_rw_data",  32'(m_if.read_data_o), 32'h4);
        mcyc(0, 0, 8'h00, 1);
        check("one_rw_next", 32'(m_if.read_data_o), 32'hD);
        mcyc(0, 0, 8'h00, 1);

        // Empty with simultaneous write and read: write only.
        mcyc(0, 1, 8'h6B, 1);
        check("emp_rw_count", 32'(m_if.count_o), 2);
        check("emp_rw_data",  32'(m_if.read_data_o), 32'h6);

        // Randomized streaming with occasional mid-stream reset; many pointer wraps.
        for (int i = 0; i < 800; i++) begin
            mcyc(($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)),
                 8'($urandom), ($urandom_range(0, 9) < 6));
        end
        mcyc(1, 0, 8'h00, 0);
        mcyc(0, 0, 8'h00, 0);

        // LSB-first ordering.
        lcyc(1, 0, 8'h00, 0);
        lcyc(0, 1, 8'hA5, 0);
        check("lsb_first",  32'(l_if.read_data_o), 32'h5);
        lcyc(0, 0, 8'h00, 1);
        check("lsb_second", 32'(l_if.read_data_o), 32'hA);
        lcyc(0, 0, 8'h00, 1);
        check("lsb_empty",  32'(l_if.empty_o), 1);

        // Wide configuration with reset asserted mid-stream.
        wcyc(1, 0, 32'h0, 0);
        wcyc(0, 1, 32'h11223344, 0);
        check("wide_count", 32'(w_if.count_o), 4);
        check("wide_full0", 32'(w_if.full_o), 0);
        check("wide_b0",    32'(w_if.read_data_o), 32'h11);
        wcyc(0, 0, 32'h0, 1);
        check("wide_b1",    32'(w_if.read_data_o), 32'h22);
        wcyc(0, 0, 32'h0, 1);
        wcyc(1, 1, 32'hDEADBEEF, 1);
        check("wide_rst_empty", 32'(w_if.empty_o), 1);
        check("wide_rst_count", 32'(w_if.count_o), 0);
        wcyc(0, 1, 32'h11223344, 0);
        for (int j = 0; j < 4; j++) begin
            check("wide_after_rst", 32'(w_if.read_data_o), 32'(8'h11 * (j + 1)));
            wcyc(0, 0, 32'h0, 1);
        end
        check("wide_final_empty", 32'(w_if.empty_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
